// File: rtl/matrix_weight_server.sv
// matrix_weight_server
//   Responder for the matrix-fetch interface. Holds a NUM_ROWS x NUM_COLS word store
//   (row-major) and answers each matrix_enable request with the BANDWIDTH-word aligned
//   line containing matrix_addr. The line is gathered one word per cycle, then
//   matrix_ready pulses for one cycle.
//
//   Optional feature (macro MATRIX_LINE_HIT_EN): one-line hit buffer. A repeat request
//   for the line already held in matrix_data skips the fetch and answers next cycle.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   wr_en          single-word write strobe (accepted in every state)
//   wr_addr        write word address
//   wr_data        write data
//   matrix_enable  fetch request level, sampled only in idle
//   matrix_addr    requested word address
//   matrix_data    line buffer, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   matrix_ready   one-cycle pulse: line valid
//   busy           high whenever the FSM is not idle
module matrix_weight_server #(
  parameter int unsigned NUM_ROWS   = 64,
  parameter int unsigned NUM_COLS   = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BANDWIDTH  = 16,
  parameter int unsigned AW         = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             matrix_enable,
  input  logic [AW-1:0]                    matrix_addr,
  output logic [DATA_WIDTH*BANDWIDTH-1:0]  matrix_data,
  output logic                             matrix_ready,
  output logic                             busy
);

  localparam int unsigned Depth = NUM_ROWS * NUM_COLS;
  localparam int unsigned CW    = (BANDWIDTH > 1) ? $clog2(BANDWIDTH) : 1;
  localparam logic [AW-1:0] LineMask = AW'(BANDWIDTH - 1);
  localparam logic [CW-1:0] LastCnt  = CW'(BANDWIDTH - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StFetch = 3'b010,
    StDone  = 3'b100
  } state_e;

  state_e                          state_q, state_d;
  logic [AW-1:0]                   base_q, base_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [DATA_WIDTH*BANDWIDTH-1:0] line_q;
  logic                            lane_we;
  logic [DATA_WIDTH-1:0]           lane_val;
  logic [AW:0]                     rd_addr;
  logic [AW-1:0]                   req_base;
  logic                            hit;

  // Word store: not reset, write lands at the clock edge.
  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign req_base = matrix_addr & ~LineMask;
  // One extra bit so base+cnt past the end of a non-power-of-two store cannot wrap.
  assign rd_addr  = {1'b0, base_q} + (AW + 1)'(cnt_q);

  // A same-cycle write to the word being fetched is forwarded, since the store
  // only reflects it after this edge.
  always_comb begin
    lane_val = '0;
    if (wr_en && ({1'b0, wr_addr} == rd_addr)) begin
      lane_val = wr_data;
    end else if (rd_addr < (AW + 1)'(Depth)) begin
      lane_val = mem[rd_addr[AW-1:0]];
    end
  end

`ifdef MATRIX_LINE_HIT_EN
  logic valid_q, valid_d;
  logic stale_q, stale_d;
  logic line_wr;

  // Base is line-aligned, so masking the write address identifies the held line.
  assign line_wr = wr_en && ((wr_addr & ~LineMask) == base_q);
  // A write into the held line in the same cycle as the request would be missed by
  // the buffer, so that request falls back to a fetch.
  assign hit     = valid_q && (req_base == base_q) && !line_wr;

  always_comb begin
    valid_d = valid_q;
    stale_d = stale_q;
    unique case (state_q)
      StIdle: begin
        if (line_wr) valid_d = 1'b0;
        if (matrix_enable && !hit) begin
          valid_d = 1'b0;
          stale_d = 1'b0;
        end
      end
      StFetch: begin
        if (line_wr) stale_d = 1'b1;
        if (cnt_q == LastCnt) valid_d = !(stale_q || line_wr);
      end
      StDone: begin
        if (line_wr) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      stale_q <= stale_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    lane_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (matrix_enable) begin
          base_d  = req_base;
          cnt_d   = '0;
          state_d = hit ? StDone : StFetch;
        end
      end
      StFetch: begin
        lane_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      if (lane_we) line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= lane_val;
    end
  end

  assign matrix_data  = line_q;
  assign matrix_ready = (state_q == StDone);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_matrix_weight_server.sv
module tb_matrix_weight_server;

`ifdef MATRIX_LINE_HIT_EN
  localparam int HitLat = 1;
`else
  localparam int HitLat = 17;
`endif
  localparam int MissLat = 17;

  logic         clk, rst;
  logic         wr_en, en, ready, busy;
  logic [11:0]  wr_addr, addr;
  logic [15:0]  wr_data;
  logic [255:0] data;

  logic         s_wr_en, s_en, s_ready, s_busy;
  logic [5:0]   s_wr_addr, s_addr;
  logic [15:0]  s_wr_data;
  logic [255:0] s_data;

  int checks = 0;
  int errors = 0;

  matrix_weight_server dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .matrix_enable(en), .matrix_addr(addr), .matrix_data(data),
    .matrix_ready(ready), .busy(busy)
  );

  matrix_weight_server #(.NUM_ROWS(5), .NUM_COLS(7)) dut_s (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .matrix_enable(s_en), .matrix_addr(s_addr), .matrix_data(s_data),
    .matrix_ready(s_ready), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] seq_line(input int first);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(first + k);
    return r;
  endfunction

  // Present a request while idle; returns in cycle T+1 (sampled #1 after the edge).
  task automatic start_req(input logic [11:0] a);
    en   = 1'b1;
    addr = a;
    @(posedge clk); #1;
    en   = 1'b0;
  endtask

  // Entered in cycle T+start; returns latency (-1 on timeout) and checks the
  // busy window and the single-cycle ready pulse.
  task automatic wait_ready(input int start, output int lat);
    int c;
    bit busy_ok;
    c = start;
    busy_ok = 1'b1;
    while (!ready && c < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    if (!busy) busy_ok = 1'b0;
    lat = ready ? c : -1;
    check("busy_window", 256'(busy_ok), 256'(1));
    @(posedge clk); #1;
    check("ready_one_cycle", 256'({ready, busy}), 256'(0));
  endtask

  task automatic write_word(input logic [11:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  typedef struct {
    logic [11:0] a;
    int          lat;
    int          lane0;
  } vec_t;

  vec_t vec[5];
  int   lat;
  bit   stray;
  logic [255:0] exp_line;

  initial begin
    vec[0] = '{a: 12'd20,   lat: MissLat, lane0: 17};
    vec[1] = '{a: 12'd23,   lat: HitLat,  lane0: 17};
    vec[2] = '{a: 12'd0,    lat: MissLat, lane0: 1};
    vec[3] = '{a: 12'd4095, lat: MissLat, lane0: 4081};
    vec[4] = '{a: 12'd4088, lat: HitLat,  lane0: 4081};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; en = 1'b0; addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_en = 1'b0; s_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 256'(ready), 256'(0));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_data", data, 256'(0));
    rst = 1'b0;

    // Fill both stores with mem[i] = i+1.
    for (int i = 0; i < 4096; i++) begin
      wr_en = 1'b1; wr_addr = 12'(i); wr_data = 16'(i + 1);
      s_wr_en = (i < 35); s_wr_addr = 6'(i); s_wr_data = 16'(i + 1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; s_wr_en = 1'b0;

    for (int v = 0; v < 5; v++) begin
      start_req(vec[v].a);
      wait_ready(1, lat);
      check($sformatf("vec%0d_latency", v), 256'(lat), 256'(vec[v].lat));
      check($sformatf("vec%0d_data", v), data, seq_line(vec[v].lane0));
    end

    // Write into a held line while idle: must refetch and see the new word.
    start_req(12'd20);
    wait_ready(1, lat);
    write_word(12'd18, 16'h7FFF);
    start_req(12'd16);
    wait_ready(1, lat);
    check("idle_write_latency", 256'(lat), 256'(MissLat));
    exp_line = seq_line(17);
    exp_line[2*16 +: 16] = 16'h7FFF;
    check("idle_write_data", data, exp_line);

    // Write to the word being fetched in the same cycle (cnt=3 at T+4).
    start_req(12'd32);
    repeat (3) begin @(posedge clk); #1; end
    write_word(12'd35, 16'h1234);
    wait_ready(5, lat);
    check("bypass_latency", 256'(lat), 256'(MissLat));
    exp_line = seq_line(33);
    exp_line[3*16 +: 16] = 16'h1234;
    check("bypass_data", data, exp_line);
    start_req(12'd33);
    wait_ready(1, lat);
    check("after_fetch_write_latency", 256'(lat), 256'(MissLat));
    check("after_fetch_write_data", data, exp_line);

    // Store smaller than the line span: out-of-range lanes read zero.
    s_en = 1'b1; s_addr = 6'd34;
    @(posedge clk); #1;
    s_en = 1'b0;
    lat = 1;
    while (!s_ready && lat < 40) begin @(posedge clk); #1; lat++; end
    check("small_latency", 256'(s_ready ? lat : -1), 256'(MissLat));
    exp_line = '0;
    exp_line[0 +: 48] = {16'd35, 16'd34, 16'd33};
    check("small_data", s_data, exp_line);

    // Reset in fetch cycle 5 (T+5): outputs clear immediately, no stray ready.
    start_req(12'd64);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midreset_ready", 256'(ready), 256'(0));
    check("midreset_busy", 256'(busy), 256'(0));
    check("midreset_data", data, 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 1'b0;
    repeat (20) begin
      if (ready || busy) stray = 1'b1;
      @(posedge clk); #1;
    end
    check("no_stray_ready", 256'(stray), 256'(0));
    start_req(12'd64);
    wait_ready(1, lat);
    check("post_reset_latency", 256'(lat), 256'(MissLat));
    check("post_reset_data", data, seq_line(65));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
